uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   Receives 8-bit asynchronous serial frames (start bit, 8 data bits LSB
//   first, optional even/odd parity bit, one stop bit). Each frame ends in
//   exactly one of three single-cycle pulses:
//   - new_data: the byte was good.
//   - parity_err: the parity bit did not match.
//   - frame_err: the stop bit was sampled low.
//
// Parameters
//   CLK_PER_BIT : clk cycles per serial bit (>= 4)
//   PARITY      : 0 = none, 1 = even, 2 = odd
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line, idle high
//   data       out  [7:0] last correctly received byte, held between frames
//   new_data   out  one-cycle pulse, data valid
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   parity_err out  one-cycle pulse, parity mismatch (always 0 if PARITY = 0)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle, waiting for rxs to fall
// START     | timing to mid start bit to reject glitches
// DATA      | sampling 8 data bits at one-bit intervals, LSB first
// PAR       | sampling the parity bit and recording mismatch
// STOP      | sampling the stop bit and issuing the result pulse
// WAIT_HIGH | after a framing error, waiting for the line to return high

module uart_rx_framer #(
  parameter int CLK_PER_BIT = 50,
  parameter int PARITY      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  // Two-flop synchronizer; both flops reset high so reset looks like idle line.
  logic rx_meta;
  logic rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             par_bad, par_bad_nxt;
  logic [7:0]       data_r, data_nxt;
  logic             new_data_r, new_data_nxt;
  logic             frame_err_r, frame_err_nxt;
  logic             parity_err_r, parity_err_nxt;
  logic             par_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shift        <= 8'h00;
      par_bad      <= 1'b0;
      data_r       <= 8'h00;
      new_data_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shift        <= shift_nxt;
      par_bad      <= par_bad_nxt;
      data_r       <= data_nxt;
      new_data_r   <= new_data_nxt;
      frame_err_r  <= frame_err_nxt;
      parity_err_r <= parity_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + CNT_W'(1);
    bit_idx_nxt    = bit_idx;
    shift_nxt      = shift;
    par_bad_nxt    = par_bad;
    data_nxt       = data_r;
    new_data_nxt   = 1'b0;
    frame_err_nxt  = 1'b0;
    parity_err_nxt = 1'b0;
    // Expected parity bit: even parity makes the total count of ones even.
    par_exp        = (PARITY == 2) ? ~(^shift) : (^shift);

    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = 3'd0;
        par_bad_nxt = 1'b0;
        if (!rxs) begin
          state_nxt = START;
        end
      end

      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (rxs) begin
            // Line went back high before mid start bit: a glitch, not a frame.
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            bit_idx_nxt = 3'd0;
          end
        end
      end

      DATA: begin
        if (cnt == CNT_FULL) begin
          // Counter restarts for every bit, not only on state entry.
          cnt_nxt     = '0;
          shift_nxt   = {rxs, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = (PARITY != 0) ? PAR : STOP;
          end
        end
      end

      PAR: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt     = '0;
          par_bad_nxt = (rxs != par_exp);
          state_nxt   = STOP;
        end
      end

      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt = '0;
          if (rxs) begin
            // Leaving at mid stop bit lets IDLE catch a back-to-back start edge.
            if (par_bad) begin
              parity_err_nxt = 1'b1;
            end else begin
              new_data_nxt = 1'b1;
              data_nxt     = shift;
            end
            state_nxt = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_HIGH;
          end
        end
      end

      WAIT_HIGH: begin
        // A held-low line (break) stays here, so only one frame_err is raised.
        cnt_nxt = '0;
        if (rxs) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign data       = data_r;
  assign new_data   = new_data_r;
  assign frame_err  = frame_err_r;
  assign parity_err = (PARITY == 0) ? 1'b0 : parity_err_r;

endmodule
